regfile_mp: RTL and testbench

- Parametrised multi-port register file for the multi-cycle and pipelined CPU datapath. Successor to the single-write, two-read register file.
- Provides NUM_RD combinational read ports and two synchronous write ports with fixed priority.
- Adds enable-gated write-through bypass and a per-register pending scoreboard (allocate, retire, flush) for hazard detection.
- Register 0 is hard-wired to zero. Register SP_IDX resets to SP_RST.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 46 ++++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int SP_IDX_DEF = 29;
  localparam logic [31:0] SP_RST_DEF = 32'h0000_03fc;

  // Bit offset of port k inside a packed multi-port bus of w-bit fields.
  function automatic int slice_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on allocate, cleared by effective writes,
// wiped by flush. Entry 0 never becomes pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr0_hit_i,
  input  logic [ADDR_W-1:0] wr0_addr_i,
  input  logic              wr1_hit_i,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              flush_i,
  output logic [DEPTH-1:0]  pend_vec_o
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Next pending state: flush dominates; otherwise clears first, then the
  // allocate so a new producer wins over a retiring one on the same entry.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (wr0_hit_i) pend_d[wr0_addr_i] = 1'b0;
      if (wr1_hit_i) pend_d[wr1_addr_i] = 1'b0;
      if (alloc_en_i && (alloc_addr_i != '0)) pend_d[alloc_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Pending bit register with asynchronous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign pend_vec_o = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised
// writes (wr1 over wr0), optional write-through bypass, pending scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                DATA_W = DATA_W_DEF,
  parameter int                ADDR_W = ADDR_W_DEF,
  parameter int                NUM_RD = 2,
  parameter int                SP_IDX = SP_IDX_DEF,
  parameter logic [DATA_W-1:0] SP_RST = DATA_W'(SP_RST_DEF),
  parameter int                BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush,
  output logic                     any_pend
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit BYP   = (BYPASS != 0);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $fatal(1, "regfile_mp: NUM_RD must be 1..4");
  end
  if (SP_IDX <= 0 || SP_IDX >= DEPTH) begin : g_bad_sp_idx
    $fatal(1, "regfile_mp: SP_IDX must be in 1..depth-1");
  end

  logic             wr0_hit;
  logic             wr1_hit;
  logic [DEPTH-1:0] pend_vec;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  // A write is effective only when enabled and not aimed at the zero register.
  assign wr0_hit = wr0_en && (wr0_addr != '0);
  assign wr1_hit = wr1_en && (wr1_addr != '0);

  // Next storage contents: wr1 applied last so it wins an address conflict.
  always_comb begin
    regs_d = regs_q;
    if (wr0_hit) regs_d[wr0_addr] = wr0_data;
    if (wr1_hit) regs_d[wr1_addr] = wr1_data;
    regs_d[0] = '0;
  end

  // Storage array; reset loads zeros plus the stack-pointer initial value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RST : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_sb (
    .clk_i        (clk),
    .reset_i      (reset),
    .wr0_hit_i    (wr0_hit),
    .wr0_addr_i   (wr0_addr),
    .wr1_hit_i    (wr1_hit),
    .wr1_addr_i   (wr1_addr),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .flush_i      (flush),
    .pend_vec_o   (pend_vec)
  );

  assign any_pend = |pend_vec;

  // Read ports: zero register, then bypass (wr1 before wr0), then storage.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              fwd1;
    logic              fwd0;

    assign addr = rd_addr[slice_off(k, ADDR_W) +: ADDR_W];
    assign fwd1 = BYP && wr1_hit && (wr1_addr == addr);
    assign fwd0 = BYP && wr0_hit && (wr0_addr == addr);

    assign rd_data[slice_off(k, DATA_W) +: DATA_W] =
      (addr == '0) ? '0       :
      fwd1         ? wr1_data :
      fwd0         ? wr0_data :
                     regs_q[addr];

    // A forwarded value resolves the hazard for this reader.
    assign rd_pend[k] = pend_vec[addr] && !(fwd0 || fwd1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one
// non-bypassing instance driven by the same stimulus.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk;
  logic            reset;
  logic            wr0_en, wr1_en;
  logic [AW-1:0]   wr0_addr, wr1_addr;
  logic [DW-1:0]   wr0_data, wr1_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]   rd_pend_b, rd_pend_n;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic            flush;
  logic            any_pend_b, any_pend_n;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pend(rd_pend_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .any_pend(any_pend_b)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pend(rd_pend_n),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .any_pend(any_pend_n)
  );

  // Clock: 10 time-unit period, first rising edge at t=5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    rd_addr = '0;

    // Asynchronous reset mid-cycle, before any clock edge.
    #2 reset = 1'b1;
    set_rd(5'd29, 5'd1);
    check("rst_sp_b", rd_data_b[31:0], 32'h0000_03fc);
    check("rst_sp_n", rd_data_n[31:0], 32'h0000_03fc);
    check("rst_anyp_b", {31'd0, any_pend_b}, 32'd0);
    check("rst_anyp_n", {31'd0, any_pend_n}, 32'd0);
    check("rst_rdp_b", {30'd0, rd_pend_b}, 32'd0);
    for (int a = 1; a < 32; a++) begin
      set_rd(5'd0, a[4:0]);
      check("rst_zero", rd_data_b[63:32], (a == 29) ? 32'h0000_03fc : 32'd0);
    end
    check("rst_x0", rd_data_b[31:0], 32'd0);
    @(negedge clk) reset = 1'b0;

    // Plain write through wr0; bypass visible only on the bypassing instance.
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hdead_beef;
    set_rd(5'd5, 5'd0);
    check("wr5_byp_b", rd_data_b[31:0], 32'hdead_beef);
    check("wr5_byp_n", rd_data_n[31:0], 32'd0);
    step(); idle_inputs(); #1;
    check("wr5_b", rd_data_b[31:0], 32'hdead_beef);
    check("wr5_n", rd_data_n[31:0], 32'hdead_beef);

    // Write to x0 is discarded and never forwarded.
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1;
    set_rd(5'd0, 5'd5);
    check("x0_byp_b", rd_data_b[31:0], 32'd0);
    step(); idle_inputs(); #1;
    check("x0_b", rd_data_b[31:0], 32'd0);
    check("x0_n", rd_data_n[31:0], 32'd0);
    check("x0_keep5", rd_data_b[63:32], 32'hdead_beef);

    // Dual write to the same address: wr1 wins.
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
    set_rd(5'd7, 5'd7);
    check("dual_byp_b", rd_data_b[31:0], 32'h22);
    check("dual_byp_n", rd_data_n[31:0], 32'd0);
    step(); idle_inputs(); #1;
    check("dual_b", rd_data_b[63:32], 32'h22);
    check("dual_n", rd_data_n[63:32], 32'h22);

    // Two different addresses in one cycle, each port forwards its own data.
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h33;
    wr1_en = 1'b1; wr1_addr = 5'd13; wr1_data = 32'h1313;
    set_rd(5'd3, 5'd13);
    check("two_byp0_b", rd_data_b[31:0], 32'h33);
    check("two_byp1_b", rd_data_b[63:32], 32'h1313);
    step(); idle_inputs(); #1;
    check("two_3_n", rd_data_n[31:0], 32'h33);
    check("two_13_n", rd_data_n[63:32], 32'h1313);

    // Disabled write port must not forward or store.
    wr0_en = 1'b0; wr0_addr = 5'd3; wr0_data = 32'hff;
    set_rd(5'd3, 5'd0);
    check("gate_byp_b", rd_data_b[31:0], 32'h33);
    step(); idle_inputs(); #1;
    check("gate_b", rd_data_b[31:0], 32'h33);

    // Scoreboard: allocate 9.
    alloc_en = 1'b1; alloc_addr = 5'd9;
    set_rd(5'd9, 5'd0);
    check("alloc_pre_b", {31'd0, rd_pend_b[0]}, 32'd0);
    step(); idle_inputs(); #1;
    check("alloc_b", {31'd0, rd_pend_b[0]}, 32'd1);
    check("alloc_n", {31'd0, rd_pend_n[0]}, 32'd1);
    check("alloc_any_b", {31'd0, any_pend_b}, 32'd1);
    check("alloc_x0p", {31'd0, rd_pend_b[1]}, 32'd0);

    // Write and re-allocate 9 together: set wins.
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
    alloc_en = 1'b1; alloc_addr = 5'd9;
    #1;
    check("realloc_cyc_b", {31'd0, rd_pend_b[0]}, 32'd0);
    check("realloc_cyc_n", {31'd0, rd_pend_n[0]}, 32'd1);
    step(); idle_inputs(); #1;
    check("realloc_b", {31'd0, rd_pend_b[0]}, 32'd1);
    check("realloc_n", {31'd0, rd_pend_n[0]}, 32'd1);

    // Write 9 alone retires it.
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'haa;
    #1;
    check("retire_cyc_b", {31'd0, rd_pend_b[0]}, 32'd0);
    check("retire_cyc_n", {31'd0, rd_pend_n[0]}, 32'd1);
    check("retire_data_b", rd_data_b[31:0], 32'haa);
    check("retire_data_n", rd_data_n[31:0], 32'h99);
    step(); idle_inputs(); #1;
    check("retire_b", {31'd0, rd_pend_b[0]}, 32'd0);
    check("retire_n", {31'd0, rd_pend_n[0]}, 32'd0);
    check("retire_any_b", {31'd0, any_pend_b}, 32'd0);

    // Flush: allocate 4, 6, 8, then flush while allocating 10 and writing 20.
    alloc_en = 1'b1; alloc_addr = 5'd4; step();
    alloc_addr = 5'd6; step();
    alloc_addr = 5'd8; step();
    idle_inputs();
    set_rd(5'd4, 5'd8);
    check("fl_pre_any", {31'd0, any_pend_b}, 32'd1);
    check("fl_pre_p", {30'd0, rd_pend_b}, 32'd3);
    set_rd(5'd6, 5'd10);
    check("fl_pre_p6", {30'd0, rd_pend_b}, 32'd1);
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd10;
    wr1_en = 1'b1; wr1_addr = 5'd20; wr1_data = 32'h5555;
    step(); idle_inputs(); #1;
    check("fl_any_b", {31'd0, any_pend_b}, 32'd0);
    check("fl_any_n", {31'd0, any_pend_n}, 32'd0);
    check("fl_p10", {30'd0, rd_pend_b}, 32'd0);
    set_rd(5'd4, 5'd20);
    check("fl_p4", {31'd0, rd_pend_b[0]}, 32'd0);
    check("fl_wr20_b", rd_data_b[63:32], 32'h5555);
    check("fl_wr20_n", rd_data_n[63:32], 32'h5555);

    // Reset asserted while a write is set up: write is lost.
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234;
    alloc_en = 1'b1; alloc_addr = 5'd12;
    #2 reset = 1'b1;
    set_rd(5'd5, 5'd29);
    check("rst2_5_n", rd_data_n[31:0], 32'd0);
    check("rst2_sp_b", rd_data_b[63:32], 32'h0000_03fc);
    step(); idle_inputs();
    @(negedge clk) reset = 1'b0;
    #1;
    check("rst2_5_b", rd_data_b[31:0], 32'd0);
    check("rst2_any_b", {31'd0, any_pend_b}, 32'd0);
    set_rd(5'd7, 5'd13);
    check("rst2_7_b", rd_data_b[31:0], 32'd0);
    check("rst2_13_n", rd_data_n[63:32], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
